// File: rtl/nexi_pic_pkg.sv
// Shared definitions for the nexi PIC: scheduler state encodings, PIC register
// field positions and the default spurious vector.
package nexi_pic_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_PRESENT = 2'd2,
    S_ACK     = 2'd3
  } state_e;

  localparam int PIC_M_BIT     = 15;
  localparam int PIC_A_BIT     = 14;
  localparam int PIC_PRIO_MSB  = 10;
  localparam int PIC_PRIO_LSB  = 8;
  localparam int PIC_VEC_MSB   = 7;
  localparam int PIC_VEC_LSB   = 0;

  localparam logic [7:0] SPURIOUS_VEC_DEFAULT = 8'h18;

endpackage

// File: rtl/nexi_pic_isr_level.sv
// Current in-service level: highest priority among sources whose isr bit is set.
module nexi_pic_isr_level #(
  parameter int N_INT_IRQ = 4
) (
  input  logic [N_INT_IRQ-1:0]   i_isr,
  input  logic [3*N_INT_IRQ-1:0] i_prio,
  output logic [2:0]             o_lvl
);

  always_comb begin
    o_lvl = '0;
    for (int i = 0; i < N_INT_IRQ; i++) begin
      if (i_isr[i] && (i_prio[3*i +: 3] > o_lvl)) o_lvl = i_prio[3*i +: 3];
    end
  end

endmodule

// File: rtl/nexi_irq_sched.sv
// Per-CPU interrupt scheduler: sequential priority scan, m68k-style IPL/IACK, in-service tracking.
// state     | meaning
// S_IDLE    | no level presented; waits for an eligible source
// S_SCAN    | walks one source per cycle to find the best candidate
// S_PRESENT | best_prio driven on ipl_o; waits for iack or withdraws
// S_ACK     | single acknowledge cycle, then back to S_IDLE
module nexi_irq_sched
  import nexi_pic_pkg::*;
#(
  parameter int         N_INT_IRQ    = 4,
  parameter int         IDX_W        = 2,
  parameter logic [7:0] SPURIOUS_VEC = SPURIOUS_VEC_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_INT_IRQ-1:0]   irq_i,
  input  logic [N_INT_IRQ-1:0]   mask_i,
  input  logic [3*N_INT_IRQ-1:0] prio_i,
  input  logic [8*N_INT_IRQ-1:0] vec_i,
  input  logic                   iack_i,
  input  logic [2:0]             iack_lvl_i,
  output logic                   ack_o,
  output logic [7:0]             vector_o,
  output logic [2:0]             ipl_o,
  input  logic                   eoi_i,
  input  logic [IDX_W-1:0]       eoi_src_i,
  output logic [N_INT_IRQ-1:0]   isr_o,
  output logic                   busy_o
);

  state_e                 r_state, w_state_nxt;
  logic [N_INT_IRQ-1:0]   r_snap, r_isr;
  logic [IDX_W-1:0]       r_idx, r_best_idx;
  logic [2:0]             r_best_prio, r_ipl;
  logic [7:0]             r_best_vec, r_vec;
  logic                   r_ack, r_iack_blk;

  logic [2:0]             w_cur_lvl, w_prio_idx, w_scan_prio;
  logic [7:0]             w_vec_idx;
  logic [N_INT_IRQ-1:0]   w_elig, w_sel_idx, w_sel_best, w_outrank, w_eoi_clr, w_isr_set;
  logic                   w_scan_hit, w_scan_last, w_withdraw, w_iack_req, w_iack_take;
  logic                   w_ack_nxt;
  logic [7:0]             w_vec_nxt;
  logic [2:0]             w_ipl_nxt;

  nexi_pic_isr_level #(.N_INT_IRQ(N_INT_IRQ)) u_isr_level (
    .i_isr  (r_isr),
    .i_prio (prio_i),
    .o_lvl  (w_cur_lvl)
  );

  always_comb begin
    w_sel_idx  = '0;
    w_sel_best = '0;
    w_prio_idx = '0;
    w_vec_idx  = '0;
    w_elig     = '0;
    w_outrank  = '0;
    w_eoi_clr  = '0;
    for (int i = 0; i < N_INT_IRQ; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_idx[i] = 1'b1;
        w_prio_idx   = prio_i[3*i +: 3];
        w_vec_idx    = vec_i[8*i +: 8];
      end
      w_sel_best[i] = (r_best_idx == IDX_W'(i));
      w_elig[i]     = irq_i[i] & ~mask_i[i] & ~r_isr[i] & (prio_i[3*i +: 3] > w_cur_lvl);
      w_outrank[i]  = w_elig[i] & ~w_sel_best[i] & (prio_i[3*i +: 3] > r_best_prio);
      w_eoi_clr[i]  = eoi_i & (eoi_src_i == IDX_W'(i));
    end
  end

  assign w_scan_hit  = (|(r_snap & w_sel_idx)) && (w_prio_idx > r_best_prio);
  assign w_scan_prio = w_scan_hit ? w_prio_idx : r_best_prio;
  assign w_scan_last = (r_idx == IDX_W'(N_INT_IRQ-1));
  assign w_withdraw  = ~(|(irq_i & w_sel_best)) | (|(mask_i & w_sel_best)) | (|w_outrank);
  assign w_iack_req  = iack_i & ~r_iack_blk;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_isr       <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_prio <= '0;
      r_best_vec  <= '0;
      r_ipl       <= '0;
      r_vec       <= '0;
      r_ack       <= 1'b0;
      r_iack_blk  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_vec      <= w_vec_nxt;
      r_ipl      <= w_ipl_nxt;
      // set beats a same-cycle EOI on the same bit
      r_isr      <= (r_isr & ~w_eoi_clr) | w_isr_set;
      r_iack_blk <= iack_i & (r_iack_blk | w_iack_take);
      if (r_state == S_IDLE && w_state_nxt == S_SCAN) begin
        r_snap      <= w_elig;
        r_idx       <= '0;
        r_best_prio <= '0;
        r_best_idx  <= '0;
        r_best_vec  <= '0;
      end else if (r_state == S_SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_scan_hit) begin
          r_best_prio <= w_prio_idx;
          r_best_idx  <= r_idx;
          r_best_vec  <= w_vec_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!w_iack_req && (|w_elig)) w_state_nxt = S_SCAN;
      S_SCAN:    if (w_iack_req) w_state_nxt = S_IDLE;
                 else if (w_scan_last) w_state_nxt = (w_scan_prio != 3'd0) ? S_PRESENT : S_IDLE;
      S_PRESENT: if (w_withdraw) w_state_nxt = S_IDLE;
                 else if (w_iack_req) w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt   = 1'b0;
    w_vec_nxt   = r_vec;
    w_ipl_nxt   = r_ipl;
    w_isr_set   = '0;
    w_iack_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ipl_nxt = '0;
        if (w_iack_req) begin
          w_iack_take = 1'b1;
          w_ack_nxt   = 1'b1;
          w_vec_nxt   = SPURIOUS_VEC;
        end
      end
      S_SCAN: begin
        if (w_iack_req) begin
          w_iack_take = 1'b1;
          w_ack_nxt   = 1'b1;
          w_vec_nxt   = SPURIOUS_VEC;
        end else if (w_scan_last) begin
          w_ipl_nxt = w_scan_prio;
        end
      end
      S_PRESENT: begin
        if (w_withdraw) begin
          w_ipl_nxt = '0;
        end else if (w_iack_req) begin
          w_iack_take = 1'b1;
          w_ack_nxt   = 1'b1;
          if (iack_lvl_i == r_best_prio) begin
            w_vec_nxt = r_best_vec;
            w_isr_set = w_sel_best;
            w_ipl_nxt = '0;
          end else begin
            w_vec_nxt = SPURIOUS_VEC;
          end
        end
      end
      default: w_ipl_nxt = '0;
    endcase
  end

  assign ack_o    = r_ack;
  assign vector_o = r_vec;
  assign ipl_o    = r_ipl;
  assign isr_o    = r_isr;
  assign busy_o   = (r_state != S_IDLE);

endmodule

// File: tb/tb_nexi_irq_sched.sv
// Directed bench for nexi_irq_sched: hand-computed IPL, acknowledge, nesting and EOI scenarios.
module tb_nexi_irq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq, mask, isr;
  logic [11:0] prio;
  logic [31:0] vec;
  logic        iack, eoi, ack, busy;
  logic [2:0]  iack_lvl, ipl;
  logic [1:0]  eoi_src;
  logic [7:0]  vector;

  int n_chk  = 0;
  int n_pass = 0;

  nexi_irq_sched #(.N_INT_IRQ(4), .IDX_W(2), .SPURIOUS_VEC(8'h18)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .mask_i     (mask),
    .prio_i     (prio),
    .vec_i      (vec),
    .iack_i     (iack),
    .iack_lvl_i (iack_lvl),
    .ack_o      (ack),
    .vector_o   (vector),
    .ipl_o      (ipl),
    .eoi_i      (eoi),
    .eoi_src_i  (eoi_src),
    .isr_o      (isr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [2:0] p, input logic [7:0] v);
    prio[3*i +: 3] = p;
    vec[8*i +: 8]  = v;
  endtask

  task automatic pulse_eoi(input logic [1:0] src);
    eoi = 1'b1; eoi_src = src;
    step(1);
    eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = '0; mask = '0; prio = '0; vec = '0;
    iack = 1'b0; iack_lvl = '0; eoi = 1'b0; eoi_src = '0;
    step(2);
    chk("rst_ipl", int'(ipl), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_vector", int'(vector), 0);
    chk("rst_isr", int'(isr), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // single source
    set_src(2, 3'd5, 8'h42);
    irq = 4'b0100;
    step(1); chk("t1_busy", int'(busy), 1);
    step(3); chk("t1_ipl_early", int'(ipl), 0);
    step(1); chk("t1_ipl", int'(ipl), 5);
    iack = 1'b1; iack_lvl = 3'd5;
    step(1);
    chk("t1_ack", int'(ack), 1);
    chk("t1_vector", int'(vector), 'h42);
    chk("t1_isr", int'(isr), 'b0100);
    chk("t1_ipl_clr", int'(ipl), 0);
    iack = 1'b0;
    step(1);
    chk("t1_ack_once", int'(ack), 0);
    chk("t1_vector_hold", int'(vector), 'h42);
    irq = '0;
    pulse_eoi(2'd2);
    chk("t1_eoi", int'(isr), 0);

    // priority and tie
    set_src(0, 3'd3, 8'h30);
    set_src(1, 3'd6, 8'h31);
    set_src(3, 3'd6, 8'h33);
    irq = 4'b1011;
    step(5); chk("t2_ipl", int'(ipl), 6);
    iack = 1'b1; iack_lvl = 3'd6;
    step(1);
    chk("t2_ack", int'(ack), 1);
    chk("t2_vector_tie", int'(vector), 'h31);
    chk("t2_isr", int'(isr), 'b0010);
    iack = 1'b0;
    step(3);
    chk("t2_nest_block", int'(ipl), 0);
    chk("t2_idle", int'(busy), 0);
    pulse_eoi(2'd1);
    chk("t2_eoi", int'(isr), 0);
    step(5); chk("t2_ipl_src3", int'(ipl), 6);
    iack = 1'b1; iack_lvl = 3'd7;
    step(1);
    chk("t2_spur_ack", int'(ack), 1);
    chk("t2_spur_vector", int'(vector), 'h18);
    chk("t2_spur_isr", int'(isr), 0);
    iack = 1'b0; irq = '0;
    step(2);
    chk("t2_ipl_end", int'(ipl), 0);
    chk("t2_busy_end", int'(busy), 0);

    // withdrawal and mask
    set_src(2, 3'd4, 8'h44);
    irq = 4'b0100;
    step(5); chk("t3_ipl", int'(ipl), 4);
    irq = '0;
    step(1);
    chk("t3_withdraw_ipl", int'(ipl), 0);
    chk("t3_withdraw_busy", int'(busy), 0);
    irq = 4'b0100;
    step(5); chk("t3_rescan_ipl", int'(ipl), 4);
    mask = 4'b0100;
    step(1); chk("t3_mask_ipl", int'(ipl), 0);
    mask = '0;
    step(5); chk("t3_unmask_ipl", int'(ipl), 4);
    iack = 1'b1; iack_lvl = 3'd4;
    step(1);
    chk("t3_vector", int'(vector), 'h44);
    chk("t3_isr", int'(isr), 'b0100);
    iack = 1'b0; irq = '0;
    step(1);
    pulse_eoi(2'd2);
    chk("t3_eoi", int'(isr), 0);

    // nesting
    set_src(0, 3'd3, 8'h50);
    irq = 4'b0001;
    step(5); chk("t4_ipl3", int'(ipl), 3);
    iack = 1'b1; iack_lvl = 3'd3;
    step(1);
    chk("t4_vector0", int'(vector), 'h50);
    chk("t4_isr0", int'(isr), 'b0001);
    iack = 1'b0; irq = '0;
    step(1);
    set_src(1, 3'd2, 8'h51);
    irq = 4'b0010;
    step(6); chk("t4_low_blocked", int'(ipl), 0);
    irq = 4'b0110;
    step(5); chk("t4_preempt_ipl", int'(ipl), 4);
    iack = 1'b1; iack_lvl = 3'd4;
    step(1);
    chk("t4_vector2", int'(vector), 'h44);
    chk("t4_isr02", int'(isr), 'b0101);
    iack = 1'b0; irq = 4'b0010;
    step(1);
    pulse_eoi(2'd0);
    chk("t4_eoi0", int'(isr), 'b0100);
    step(5); chk("t4_still_blocked", int'(ipl), 0);
    pulse_eoi(2'd3);
    chk("t4_eoi_noop", int'(isr), 'b0100);
    pulse_eoi(2'd2);
    chk("t4_eoi2", int'(isr), 0);
    step(5); chk("t4_ipl2", int'(ipl), 2);

    // reset during the acknowledge cycle
    iack = 1'b1; iack_lvl = 3'd2;
    step(1);
    chk("t5_ack", int'(ack), 1);
    chk("t5_vector", int'(vector), 'h51);
    chk("t5_isr", int'(isr), 'b0010);
    rst = 1'b1; iack = 1'b0;
    step(1);
    chk("t5_rst_ack", int'(ack), 0);
    chk("t5_rst_ipl", int'(ipl), 0);
    chk("t5_rst_isr", int'(isr), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_vector", int'(vector), 0);
    rst = 1'b0;

    // iack during a scan aborts it; a held iack is ignored afterwards
    step(1); chk("t6_scan_busy", int'(busy), 1);
    iack = 1'b1; iack_lvl = 3'd2;
    step(1);
    chk("t6_ack", int'(ack), 1);
    chk("t6_vector", int'(vector), 'h18);
    chk("t6_abort_busy", int'(busy), 0);
    step(1);
    chk("t6_held_ignored", int'(ack), 0);
    iack = 1'b0;
    step(4); chk("t6_ipl", int'(ipl), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
